clk_tick_sync: RTL and testbench

CLK_TICK_SYNC -- requirements
Module: clk_tick_sync

---
 rtl/clk_tick_sync_pkg.sv | 18 +
 rtl/sync_2ff.sv | 22 ++
 rtl/clk_tick_sync.sv | 137 +++++++++++++
 tb/tb_clk_tick_sync.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/clk_tick_sync_pkg.sv
// Shared definitions for clk_tick_sync: FSM state encoding and parameter defaults.
// Optional feature macro: TICK_PERIOD_MEAS_EN (period measurement outputs).
package clk_tick_sync_pkg;

    localparam int CNT_W_DEF   = 24;
    localparam int TIMEOUT_DEF = 4194304;

    // Cycles after reset release during which edge detection stays masked,
    // so the history register can settle on the synchronized level.
    localparam logic [1:0] WARM_DONE = 2'd3;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        LOCKED     = 2'd1,
        LOST       = 2'd2
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset value 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give metastability time to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_tick_sync.sv
// clk_tick_sync: turns an asynchronous slow clock into one-cycle rise/fall
// ticks in the clk domain, tracks lock/loss with a timeout counter and, when
// TICK_PERIOD_MEAS_EN is defined, reports the measured rise-to-rise period.
// state_dbg exposes the FSM state for observation.
module clk_tick_sync
    import clk_tick_sync_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             slow_clk,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             locked,
    output logic             lost,
`ifdef TICK_PERIOD_MEAS_EN
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
`endif
    output state_t           state_dbg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             slow_sync;
    logic             slow_hist;
    logic [1:0]       warm;
    logic             rise_q;
    logic             fall_q;
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             per_load;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (slow_clk),
        .q     (slow_sync)
    );

    // History register and registered edge detect, masked during warm-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slow_hist <= 1'b0;
            warm      <= 2'd0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            slow_hist <= slow_sync;
            if (warm != WARM_DONE) begin
                warm <= warm + 2'd1;
            end
            rise_q <= (warm == WARM_DONE) &&  slow_sync && !slow_hist;
            fall_q <= (warm == WARM_DONE) && !slow_sync &&  slow_hist;
        end
    end

    // Next-state and counter logic; a rising edge beats a same-cycle timeout.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        per_load = 1'b0;
        case (state)
            WAIT_FIRST: begin
                cnt_nx = '0;
                if (rise_q) begin
                    state_nx = LOCKED;
                end
            end
            LOCKED: begin
                if (rise_q) begin
                    cnt_nx   = '0;
                    per_load = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nx = LOST;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            LOST: begin
                if (rise_q) begin
                    state_nx = LOCKED;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = WAIT_FIRST;
                cnt_nx   = '0;
            end
        endcase
    end

    // State register, counter, ticks and registered state decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_FIRST;
            cnt       <= '0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
            locked    <= 1'b0;
            lost      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            tick_rise <= rise_q;
            tick_fall <= fall_q;
            locked    <= (state_nx == LOCKED);
            lost      <= (state_nx == LOST);
        end
    end

`ifdef TICK_PERIOD_MEAS_EN
    // Period capture: only rises seen while LOCKED have a valid start point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= per_load;
            if (per_load) begin
                period <= cnt + CNT_ONE;
            end
        end
    end
`else
    logic unused_per_load;
    assign unused_per_load = per_load;
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_clk_tick_sync.sv
// Directed bench for clk_tick_sync with TIMEOUT=20; period checks apply
// when TICK_PERIOD_MEAS_EN is defined.
module tb_clk_tick_sync;
    import clk_tick_sync_pkg::*;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             slow_clk;
    logic             tick_rise;
    logic             tick_fall;
    logic             locked;
    logic             lost;
    state_t           state_dbg;
`ifdef TICK_PERIOD_MEAS_EN
    logic [CNT_W-1:0] period;
    logic             period_valid;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    clk_tick_sync #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .slow_clk     (slow_clk),
        .tick_rise    (tick_rise),
        .tick_fall    (tick_fall),
        .locked       (locked),
        .lost         (lost),
`ifdef TICK_PERIOD_MEAS_EN
        .period       (period),
        .period_valid (period_valid),
`endif
        .state_dbg    (state_dbg)
    );

    // Clock: 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_tick_rise"}, 32'(tick_rise), 32'd0);
        check({tag, "_tick_fall"}, 32'(tick_fall), 32'd0);
        check({tag, "_locked"},    32'(locked),    32'd0);
        check({tag, "_lost"},      32'(lost),      32'd0);
    endtask

    // Drive one slow_clk level for n cycles; the transition tick is due on
    // the 4th sample (3 cycles after the first sampling edge).
    task automatic half(input logic level, input int n, input logic exp_pv);
        slow_clk = level;
        for (int i = 0; i < n; i++) begin
            step();
            check($sformatf("tick_rise_l%0d_i%0d", level, i), 32'(tick_rise), 32'(level && i == 3));
            check($sformatf("tick_fall_l%0d_i%0d", level, i), 32'(tick_fall), 32'(!level && i == 3));
`ifdef TICK_PERIOD_MEAS_EN
            check($sformatf("period_valid_l%0d_i%0d", level, i), 32'(period_valid),
                  32'(level && i == 3 && exp_pv));
`endif
            if (level && i == 3) begin
                check("locked_at_rise", 32'(locked), 32'd1);
                check("lost_at_rise",   32'(lost),   32'd0);
            end
        end
    endtask

    task automatic check_period(input string tag, input int exp);
`ifdef TICK_PERIOD_MEAS_EN
        check(tag, 32'(period), 32'(exp));
`else
        if (exp < 0) $display("unexpected period argument %0d for %s", exp, tag);
`endif
    endtask

    initial begin
        // Reset with slow_clk held high.
        rst_n    = 1'b0;
        slow_clk = 1'b1;
        step();
        step();
        check_quiet("reset");
        check("reset_state", 32'(state_dbg), 32'(WAIT_FIRST));
        check_period("reset_period", 0);

        // Release: the high level present at release must not tick.
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_quiet($sformatf("post_release_%0d", i));
        end

        // Square wave, period 8: first rise locks without a period strobe.
        half(1'b0, 4, 1'b0);
        half(1'b1, 4, 1'b0);
        check_period("period_first_rise", 0);
        for (int k = 0; k < 3; k++) begin
            half(1'b0, 4, 1'b0);
            half(1'b1, 4, 1'b1);
            check_period($sformatf("period_8_%0d", k), 8);
        end

        // slow_clk stops high: lost exactly 20 cycles after the last clear.
        for (int i = 1; i <= 20; i++) begin
            step();
            check($sformatf("timeout_lost_%0d", i),   32'(lost),   32'(i == 20));
            check($sformatf("timeout_locked_%0d", i), 32'(locked), 32'(i != 20));
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("lost_hold_%0d", i), 32'(lost), 32'd1);
            check($sformatf("lost_state_%0d", i), 32'(state_dbg), 32'(LOST));
        end
        half(1'b0, 4, 1'b0);
        check("lost_after_fall", 32'(lost), 32'd1);
        half(1'b1, 4, 1'b0);
        check_period("period_retained_after_lost", 8);

        // Rise lands exactly when the counter reaches TIMEOUT-1: edge wins.
        half(1'b0, 16, 1'b0);
        half(1'b1, 4, 1'b1);
        check_period("period_20_boundary", 20);
        check("boundary_state", 32'(state_dbg), 32'(LOCKED));

        // Reset pulse while a rising edge is in flight.
        half(1'b0, 4, 1'b0);
        slow_clk = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("midreset");
        check("midreset_state", 32'(state_dbg), 32'(WAIT_FIRST));
        check_period("midreset_period", 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_quiet($sformatf("post_midreset_%0d", i));
        end
        half(1'b0, 4, 1'b0);
        half(1'b1, 4, 1'b0);
        check_period("period_after_midreset", 0);
        half(1'b0, 4, 1'b0);
        half(1'b1, 4, 1'b1);
        check_period("period_8_after_midreset", 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
